rails_gen: RTL



---
 rtl/rails_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rails_gen.sv
// Departure-order generator for the rails checker: simulates the station stack from an
// op string, then streams one number beat and N data beats. Option: RAILS_GEN_CORRUPT_EN.
module rails_gen #(
    parameter int MAX_N = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  n_in,
    input  logic [19:0] ops,
    input  logic        corrupt,
    output logic        busy,
    output logic        num_valid,
    output logic [3:0]  number,
    output logic        data_valid,
    output logic [3:0]  data,
    output logic        done,
    output logic        expected
);

    typedef enum logic [2:0] {S_IDLE, S_BUILD, S_NUM, S_SEND, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  n_q, n_d, nxt_q, nxt_d, sp_q, sp_d, wr_q, wr_d, rd_q, rd_d;
    logic [4:0]  k_q, k_d;
    logic [19:0] ops_q, ops_d;
    logic        cor_q, cor_d;
    logic        busy_q, busy_d, num_valid_q, num_valid_d, data_valid_q, data_valid_d;
    logic        done_q, done_d, expected_q, expected_d;
    logic [3:0]  number_q, number_d, data_q, data_d;

    logic [3:0]  stack_q [MAX_N];
    logic [3:0]  order_q [MAX_N];
    logic        stk_we, ord_we, push;
    logic [3:0]  ord_wa, ord_wd, stk_top, n_cl;
    logic [4:0]  k_last;
    logic        cor_take;

    assign n_cl    = (n_in > 4'(MAX_N)) ? 4'(MAX_N) : n_in;
    assign stk_top = stack_q[sp_q - 4'd1];
    assign k_last  = {n_q, 1'b0} - 5'd1;
    // Pops on an empty stack become pushes, pushes past N become pops.
    assign push    = (sp_q == 4'd0) || (ops_q[k_q] && (nxt_q <= n_q));

`ifdef RAILS_GEN_CORRUPT_EN
    assign cor_take = corrupt && (n_cl >= 4'd3);
`else
    logic unused_corrupt;
    assign unused_corrupt = corrupt;
    assign cor_take = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        nxt_d   = nxt_q;
        sp_d    = sp_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        k_d     = k_q;
        ops_d   = ops_q;
        cor_d   = cor_q;
        stk_we  = 1'b0;
        ord_we  = 1'b0;
        ord_wa  = wr_q;
        ord_wd  = stk_top;
        case (state_q)
            S_IDLE: if (start) begin
                n_d     = n_cl;
                ops_d   = ops;
                cor_d   = cor_take;
                k_d     = 5'd0;
                nxt_d   = 4'd1;
                sp_d    = 4'd0;
                wr_d    = 4'd0;
                state_d = (n_cl == 4'd0) ? S_NUM : S_BUILD;
            end
            S_BUILD: begin
                k_d = k_q + 5'd1;
                if (cor_q) begin
                    // Order N,1,2,..,N-1 written over the first N cycles; length stays 2N.
                    if (k_q < {1'b0, n_q}) begin
                        ord_we = 1'b1;
                        ord_wa = k_q[3:0];
                        ord_wd = (k_q == 5'd0) ? n_q : k_q[3:0];
                    end
                end else if (push) begin
                    stk_we = 1'b1;
                    sp_d   = sp_q + 4'd1;
                    nxt_d  = nxt_q + 4'd1;
                end else begin
                    ord_we = 1'b1;
                    sp_d   = sp_q - 4'd1;
                    wr_d   = wr_q + 4'd1;
                end
                if (k_q == k_last) state_d = S_NUM;
            end
            S_NUM: begin
                rd_d    = 4'd0;
                state_d = (n_q == 4'd0) ? S_DONE : S_SEND;
            end
            S_SEND: begin
                rd_d = rd_q + 4'd1;
                if (rd_q == n_q - 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered off the next state so each strobe lines up with its state.
        busy_d       = (state_d != S_IDLE);
        num_valid_d  = (state_d == S_NUM);
        number_d     = (state_d == S_NUM) ? n_d : number_q;
        data_valid_d = (state_d == S_SEND);
        data_d       = (state_d == S_SEND) ? order_q[rd_d] : data_q;
        done_d       = (state_d == S_DONE);
        expected_d   = (state_d == S_DONE) ? ~cor_q : expected_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            n_q          <= 4'd0;
            nxt_q        <= 4'd0;
            sp_q         <= 4'd0;
            wr_q         <= 4'd0;
            rd_q         <= 4'd0;
            k_q          <= 5'd0;
            ops_q        <= 20'd0;
            cor_q        <= 1'b0;
            busy_q       <= 1'b0;
            num_valid_q  <= 1'b0;
            number_q     <= 4'd0;
            data_valid_q <= 1'b0;
            data_q       <= 4'd0;
            done_q       <= 1'b0;
            expected_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            nxt_q        <= nxt_d;
            sp_q         <= sp_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            k_q          <= k_d;
            ops_q        <= ops_d;
            cor_q        <= cor_d;
            busy_q       <= busy_d;
            num_valid_q  <= num_valid_d;
            number_q     <= number_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            done_q       <= done_d;
            expected_q   <= expected_d;
        end
    end

    always_ff @(posedge clk) begin
        if (stk_we) stack_q[sp_q] <= nxt_q;
        if (ord_we) order_q[ord_wa] <= ord_wd;
    end

    assign busy       = busy_q;
    assign num_valid  = num_valid_q;
    assign number     = number_q;
    assign data_valid = data_valid_q;
    assign data       = data_q;
    assign done       = done_q;
    assign expected   = expected_q;

endmodule
